// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the cache-miss, store, memory and fill signals of mem_arbiter.
//   master : arbiter side (takes requests and read data, drives memory, fill and status)
//   slave  : environment side (cache controllers plus the unified memory)
// Signals:
//   i_miss/i_addr, d_miss/d_addr : line-miss requests, held until the matching *_fill_done
//   wr_req/wr_addr/wr_data       : store request, held until wr_ack
//   mem_*                        : pipelined fixed-latency memory port
//   fill_*                       : one returned line word per fill_we pulse
//   i_fill_done/d_fill_done/busy : completion pulses and activity status
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned CNT_W  = 3
);
  logic              i_miss;
  logic [ADDR_W-1:0] i_addr;
  logic              d_miss;
  logic [ADDR_W-1:0] d_addr;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic              wr_ack;
  logic              mem_enable;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_data_in;
  logic [15:0]       mem_data_out;
  logic              mem_data_valid;
  logic              fill_we;
  logic              fill_sel;
  logic [CNT_W-1:0]  fill_word;
  logic [15:0]       fill_data;
  logic              i_fill_done;
  logic              d_fill_done;
  logic              busy;

  modport master (
    input  i_miss, i_addr, d_miss, d_addr, wr_req, wr_addr, wr_data,
    input  mem_data_out, mem_data_valid,
    output wr_ack, mem_enable, mem_wr, mem_addr, mem_data_in,
    output fill_we, fill_sel, fill_word, fill_data, i_fill_done, d_fill_done, busy
  );

  modport slave (
    output i_miss, i_addr, d_miss, d_addr, wr_req, wr_addr, wr_data,
    output mem_data_out, mem_data_valid,
    input  wr_ack, mem_enable, mem_wr, mem_addr, mem_data_in,
    input  fill_we, fill_sel, fill_word, fill_data, i_fill_done, d_fill_done, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one unified memory between the I-cache miss path, the D-cache miss path
// and the D-side write-through store path. Stores take one WRITE cycle; misses fetch a whole
// line with one read issued per cycle and stream the returned words to the requesting cache.
// Ports:
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   bus   : mem_arbiter_if.master (requests, memory port, fill port, done pulses, busy)
module mem_arbiter #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned LINE_WORDS = 8,
  parameter int unsigned CNT_W      = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.master bus
);

  localparam logic [CNT_W:0]    LineWords = (CNT_W + 1)'(LINE_WORDS);
  localparam logic [CNT_W-1:0]  LastWord  = CNT_W'(LINE_WORDS - 1);
  localparam logic [ADDR_W-1:0] LineMask  = ~ADDR_W'(2 * LINE_WORDS - 1);
  localparam logic [ADDR_W-1:0] WordMask  = ~ADDR_W'(1);

  typedef enum logic [1:0] {StIdle, StWrite, StFill, StDone} state_e;

  state_e            stateQ;
  // issueCntQ is one bit wider than recvCntQ so it can rest at LINE_WORDS once all reads are out.
  logic [CNT_W:0]    issueCntQ;
  logic [CNT_W-1:0]  recvCntQ;
  logic              lastGrantQ;  // 0 = I, 1 = D
  logic              selQ;        // fill target of the current line
  logic [ADDR_W-1:0] lineBaseQ;
  logic [ADDR_W-1:0] wrAddrQ;
  logic [15:0]       wrDataQ;

  logic grantD;
  logic issuing;
  logic inWrite;
  logic inFill;
  logic inDone;

  // Round-robin between misses: with both pending, the side not served last time wins.
  assign grantD = bus.d_miss & (~bus.i_miss | ~lastGrantQ);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateQ     <= StIdle;
      issueCntQ  <= '0;
      recvCntQ   <= '0;
      lastGrantQ <= 1'b0;
      selQ       <= 1'b0;
      lineBaseQ  <= '0;
      wrAddrQ    <= '0;
      wrDataQ    <= '0;
    end else begin
      unique case (stateQ)
        StIdle: begin
          if (bus.wr_req) begin
            wrAddrQ <= bus.wr_addr;
            wrDataQ <= bus.wr_data;
            stateQ  <= StWrite;
          end else if (bus.i_miss | bus.d_miss) begin
            selQ       <= grantD;
            lastGrantQ <= grantD;
            lineBaseQ  <= (grantD ? bus.d_addr : bus.i_addr) & LineMask;
            issueCntQ  <= '0;
            recvCntQ   <= '0;
            stateQ     <= StFill;
          end
        end
        StWrite: stateQ <= StIdle;
        StFill: begin
          if (issueCntQ < LineWords) issueCntQ <= issueCntQ + 1'b1;
          if (bus.mem_data_valid) begin
            recvCntQ <= recvCntQ + 1'b1;
            if (recvCntQ == LastWord) stateQ <= StDone;
          end
        end
        StDone: begin
          issueCntQ <= '0;
          recvCntQ  <= '0;
          stateQ    <= StIdle;
        end
        default: stateQ <= StIdle;
      endcase
    end
  end

  assign inWrite = (stateQ == StWrite);
  assign inFill  = (stateQ == StFill);
  assign inDone  = (stateQ == StDone);
  assign issuing = inFill & (issueCntQ < LineWords);

  // Memory-side outputs depend only on state and counters, never on the request inputs.
  always_comb begin
    bus.mem_enable  = inWrite | issuing;
    bus.mem_wr      = inWrite;
    bus.mem_addr    = '0;
    bus.mem_data_in = '0;
    if (inWrite) begin
      bus.mem_addr    = wrAddrQ & WordMask;
      bus.mem_data_in = wrDataQ;
    end else if (issuing) begin
      bus.mem_addr = lineBaseQ | ADDR_W'({issueCntQ[CNT_W-1:0], 1'b0});
    end
  end

  // Returned words are forwarded in the cycle they arrive; late data outside FILL is dropped.
  always_comb begin
    bus.fill_we     = inFill & bus.mem_data_valid;
    bus.fill_sel    = inFill & selQ;
    bus.fill_word   = inFill ? recvCntQ : '0;
    bus.fill_data   = bus.fill_we ? bus.mem_data_out : '0;
    bus.wr_ack      = inWrite;
    bus.i_fill_done = inDone & ~selQ;
    bus.d_fill_done = inDone & selQ;
    bus.busy        = (stateQ != StIdle);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: drives mem_arbiter with directed and randomized store/miss traffic against a
// behavioural memory with configurable read latency. A transaction-level model schedules, at
// each grant, the complete expected output timeline of that transaction into a cycle ring,
// and every cycle the DUT outputs are compared with it.
module tb_mem_arbiter;

  localparam int MaxLat = 8;

  typedef struct packed {
    logic        busy;
    logic        en;
    logic        wr;
    logic        ack;
    logic        we;
    logic        sel;
    logic        iDone;
    logic        dDone;
    logic [2:0]  word;
    logic [15:0] addr;
    logic [15:0] din;
    logic [15:0] fdata;
  } frame_t;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- behavioural memory ----------------
  int unsigned seed;
  bit          memLive;
  logic [2:0]  latIdx;  // latency minus one
  int          lat;
  logic [15:0] memStore   [32768];
  bit          memWritten [32768];
  logic        pipeV      [MaxLat];
  logic [15:0] pipeD      [MaxLat];

  function automatic logic [15:0] initWord(input int unsigned idx);
    logic [31:0] h;
    h = idx * 32'h9E3779B1 ^ seed;
    return h[23:8];
  endfunction

  always @(posedge clk) begin
    if (memLive && bus.mem_enable && bus.mem_wr) begin
      memStore[bus.mem_addr[15:1]]   <= bus.mem_data_in;
      memWritten[bus.mem_addr[15:1]] <= 1'b1;
    end
    pipeV[0] <= memLive && bus.mem_enable && !bus.mem_wr;
    pipeD[0] <= memWritten[bus.mem_addr[15:1]] ? memStore[bus.mem_addr[15:1]]
                                                : initWord(32'(bus.mem_addr[15:1]));
    for (int i = 1; i < MaxLat; i++) begin
      pipeV[i] <= pipeV[i-1];
      pipeD[i] <= pipeD[i-1];
    end
  end

  assign bus.mem_data_valid = pipeV[latIdx];
  assign bus.mem_data_out   = pipeD[latIdx];

  // ---------------- reference model ----------------
  logic [15:0] shadow  [32768];
  bit          shadowW [32768];
  frame_t      ring    [64];
  int          cyc;
  int          freeAt;
  bit          lastD;
  bit          checkOn;
  int          grantCyc;
  int          nCmp;
  int          nBad;
  int          iDoneCnt;
  bit          iDoneNow;
  bit          dDoneNow;
  int          doneLog [$];

  function automatic int slot(input int c);
    return c % 64;
  endfunction

  function automatic logic [15:0] expWord(input logic [14:0] idx);
    return shadowW[idx] ? shadow[idx] : initWord(32'(idx));
  endfunction

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Called right after each rising edge: cycle 'cyc' is the interval following that edge.
  task automatic modelEdge();
    int          e;
    int          s;
    bit          gd;
    logic [15:0] base;
    logic [14:0] idx;
    e = cyc;
    if (!rst_n) begin
      foreach (ring[r]) ring[r] = '0;
      freeAt  = e + 1;
      lastD   = 1'b0;
      checkOn = 1'b1;
    end else if (e >= freeAt) begin
      if (bus.wr_req) begin
        s              = slot(e);
        ring[s].busy   = 1'b1;
        ring[s].en     = 1'b1;
        ring[s].wr     = 1'b1;
        ring[s].ack    = 1'b1;
        ring[s].addr   = {bus.wr_addr[15:1], 1'b0};
        ring[s].din    = bus.wr_data;
        idx            = bus.wr_addr[15:1];
        shadow[idx]    = bus.wr_data;
        shadowW[idx]   = 1'b1;
        freeAt         = e + 2;
      end else if (bus.i_miss || bus.d_miss) begin
        if (bus.i_miss && bus.d_miss) gd = !lastD;
        else gd = bus.d_miss;
        lastD     = gd;
        base      = gd ? bus.d_addr : bus.i_addr;
        base[3:0] = 4'h0;
        grantCyc  = e;
        for (int k = 0; k < 8; k++) begin
          s              = slot(e + k);
          ring[s].en     = 1'b1;
          ring[s].addr   = base + 16'(2 * k);
          s              = slot(e + k + lat);
          ring[s].we     = 1'b1;
          ring[s].sel    = gd;
          ring[s].word   = 3'(k);
          ring[s].fdata  = expWord(base[15:1] + 15'(k));
        end
        for (int t = 0; t <= 8 + lat; t++) ring[slot(e + t)].busy = 1'b1;
        s = slot(e + 8 + lat);
        if (gd) ring[s].dDone = 1'b1;
        else ring[s].iDone = 1'b1;
        freeAt = e + lat + 10;
      end
    end
  endtask

  task automatic checkFrame();
    frame_t f;
    int     s;
    s = slot(cyc);
    f = ring[s];
    if (checkOn) begin
      checkEq("busy", 32'(bus.busy), 32'(f.busy));
      checkEq("mem_enable", 32'(bus.mem_enable), 32'(f.en));
      checkEq("mem_wr", 32'(bus.mem_wr), 32'(f.wr));
      if (f.en) checkEq("mem_addr", 32'(bus.mem_addr), 32'(f.addr));
      if (f.wr) checkEq("mem_data_in", 32'(bus.mem_data_in), 32'(f.din));
      checkEq("wr_ack", 32'(bus.wr_ack), 32'(f.ack));
      checkEq("fill_we", 32'(bus.fill_we), 32'(f.we));
      if (f.we) begin
        checkEq("fill_sel", 32'(bus.fill_sel), 32'(f.sel));
        checkEq("fill_word", 32'(bus.fill_word), 32'(f.word));
        checkEq("fill_data", 32'(bus.fill_data), 32'(f.fdata));
      end
      checkEq("i_fill_done", 32'(bus.i_fill_done), 32'(f.iDone));
      checkEq("d_fill_done", 32'(bus.d_fill_done), 32'(f.dDone));
    end
    ring[s] = '0;
  endtask

  // One clock: model at the rising edge, check and requester reactions at the falling edge.
  task automatic tick();
    @(posedge clk);
    cyc++;
    modelEdge();
    @(negedge clk);
    checkFrame();
    iDoneNow = bus.i_fill_done;
    dDoneNow = bus.d_fill_done;
    if (iDoneNow) begin
      bus.i_miss = 1'b0;
      iDoneCnt++;
      doneLog.push_back(0);
    end
    if (dDoneNow) begin
      bus.d_miss = 1'b0;
      doneLog.push_back(1);
    end
    if (bus.wr_ack) bus.wr_req = 1'b0;
  endtask

  function automatic bit pendingReq();
    return bus.wr_req || bus.i_miss || bus.d_miss;
  endfunction

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((pendingReq() || cyc < freeAt) && n < budget) begin
      tick();
      n++;
    end
    checkEq("drain", 32'(pendingReq() || cyc < freeAt), 32'd0);
    repeat (2) tick();
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  // Hold until cycle grant+offset of the next grant (bounded).
  task automatic waitGrantPlus(input int offset);
    int n;
    n = 0;
    grantCyc = -1;
    while ((grantCyc < 0 || cyc < grantCyc + offset) && n < 60) begin
      tick();
      n++;
    end
    checkEq("grant_wait", 32'(grantCyc >= 0 && cyc == grantCyc + offset), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int iLeft;
    int dLeft;
    bit iPend;
    bit dPend;
    int n;
    seed     = $urandom;
    memLive  = 1'b0;
    latIdx   = 3'd3;
    lat      = 4;
    cyc      = 0;
    freeAt   = 0;
    lastD    = 1'b0;
    checkOn  = 1'b0;
    grantCyc = -1;
    nCmp     = 0;
    nBad     = 0;
    iDoneCnt = 0;
    rst_n       = 1'b0;
    bus.i_miss  = 1'b0;
    bus.d_miss  = 1'b0;
    bus.wr_req  = 1'b0;
    bus.i_addr  = '0;
    bus.d_addr  = '0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    repeat (10) tick();
    memLive = 1'b1;
    rst_n   = 1'b1;
    tick();

    // 1: single D fill, latency 4
    bus.d_addr = 16'h1236;
    bus.d_miss = 1'b1;
    drain(100);
    checkEq("t1_busy_after", 32'(bus.busy), 32'd0);

    // 2: simultaneous misses after reset; D first, one I completion
    applyReset();
    doneLog.delete();
    iDoneCnt   = 0;
    bus.i_addr = 16'h0040;
    bus.d_addr = 16'h2000;
    bus.i_miss = 1'b1;
    bus.d_miss = 1'b1;
    drain(200);
    checkEq("t2_done_count", 32'(doneLog.size()), 32'd2);
    if (doneLog.size() == 2) begin
      checkEq("t2_first_is_d", doneLog[0], 32'd1);
      checkEq("t2_second_is_i", doneLog[1], 32'd0);
    end
    checkEq("t2_i_done_once", iDoneCnt, 32'd1);

    // 3: store wins over a miss; the miss line then returns the stored word
    bus.wr_addr = 16'h0102;
    bus.wr_data = 16'hBEEF;
    bus.wr_req  = 1'b1;
    bus.i_addr  = 16'h0100;
    bus.i_miss  = 1'b1;
    drain(200);

    // 4: store raised mid D fill, then a fill of the same line shows the stored word
    bus.d_addr = 16'h3008;
    bus.d_miss = 1'b1;
    waitGrantPlus(3);
    bus.wr_addr = 16'h3006;
    bus.wr_data = 16'($urandom);
    bus.wr_req  = 1'b1;
    drain(200);
    bus.i_addr = 16'h3000;
    bus.i_miss = 1'b1;
    drain(200);

    // 5: reset during the third issue cycle, late data ignored, then a clean fill
    bus.i_addr = 16'h5550;
    bus.i_miss = 1'b1;
    waitGrantPlus(2);
    rst_n      = 1'b0;
    bus.i_miss = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (lat + 4) tick();
    bus.i_miss = 1'b1;
    drain(200);

    // 6: both misses held for three lines each: D, I, D, I, D, I
    applyReset();
    doneLog.delete();
    iLeft      = 3;
    dLeft      = 3;
    iPend      = 1'b0;
    dPend      = 1'b0;
    bus.i_addr = 16'h7000;
    bus.d_addr = 16'h8000;
    bus.i_miss = 1'b1;
    bus.d_miss = 1'b1;
    n = 0;
    while ((iLeft > 0 || dLeft > 0) && n < 400) begin
      tick();
      n++;
      if (iPend) begin
        bus.i_addr = bus.i_addr + 16'h0010;
        bus.i_miss = 1'b1;
        iPend      = 1'b0;
      end
      if (dPend) begin
        bus.d_addr = bus.d_addr + 16'h0010;
        bus.d_miss = 1'b1;
        dPend      = 1'b0;
      end
      if (iDoneNow) begin
        iLeft--;
        iPend = (iLeft > 0);
      end
      if (dDoneNow) begin
        dLeft--;
        dPend = (dLeft > 0);
      end
    end
    drain(100);
    checkEq("t6_done_count", 32'(doneLog.size()), 32'd6);
    for (int k = 0; k < 6; k++) begin
      if (k < doneLog.size()) checkEq("t6_order", doneLog[k], (k % 2 == 0) ? 32'd1 : 32'd0);
    end

    // Randomized traffic: random mix, addresses, staggered arrival and memory latency
    for (int it = 0; it < 40; it++) begin
      logic [2:0] mask;
      int         dW;
      int         dI;
      int         dD;
      int         t;
      latIdx = 3'($urandom_range(0, 5));
      lat    = int'(latIdx) + 1;
      mask   = 3'($urandom_range(1, 7));
      dW     = int'($urandom_range(0, 12));
      dI     = int'($urandom_range(0, 12));
      dD     = int'($urandom_range(0, 12));
      t      = 0;
      while ((t <= 12 || pendingReq()) && t < 400) begin
        if (mask[0] && t == dW) begin
          bus.wr_addr = 16'($urandom);
          bus.wr_data = 16'($urandom);
          bus.wr_req  = 1'b1;
        end
        if (mask[1] && t == dI) begin
          bus.i_addr = 16'($urandom);
          bus.i_miss = 1'b1;
        end
        if (mask[2] && t == dD) begin
          bus.d_addr = 16'($urandom);
          bus.d_miss = 1'b1;
        end
        tick();
        t++;
      end
      drain(200);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
